// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store path.
package dmem_pkg;

    // Number of byte-address bits backed by dmem.
    localparam int DMEM_AW_DEF = 17;

    // dmem memop encoding
    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_HI,
        RD_LO,
        WR_HI,
        WR_LO,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_check.sv
// Request legality check: op legality, natural alignment and dmem range.
// Purely combinational so the core can reuse it for exception causes.
module dmem_lsu_check
    import dmem_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEF
) (
    input  logic [2:0]  op_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    output logic        err_o
);

    logic op_bad;
    logic misaligned;
    logic out_of_range;

    // Any single reason rejects the request.
    always_comb begin
        op_bad = 1'b0;
        if (we_i) begin
            // stores have no unsigned variants
            op_bad = !((op_i == MOP_B) || (op_i == MOP_H) || (op_i == MOP_W));
        end else begin
            op_bad = (op_i == 3'b011) || (op_i == 3'b110) || (op_i == 3'b111);
        end
        misaligned = (((op_i == MOP_H) || (op_i == MOP_HU)) && addr_i[0]) ||
                     ((op_i == MOP_W) && (addr_i[1:0] != 2'b00));
        out_of_range = (addr_i >> DMEM_AW) != 32'd0;
        err_o = op_bad | misaligned | out_of_range;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer between the core memory request and dmem.
// Drives registered, glitch-free dmem read/write strobes; stores always
// do a read strobe first so dmem can merge byte/half data into the old word.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemdatain,
    input  logic [31:0] dmemdataout,
    output logic [2:0]  dmemop,
    output logic        dmemwe,
    output logic        dmemrdclk,
    output logic        dmemwrclk
);

    lsu_state_e  state_q;
    logic        err_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] addr_q;
    logic [31:0] datain_q;
    logic [2:0]  op_q;
    logic        we_q;
    logic        rdclk_q;
    logic        wrclk_q;
    logic        err_d;

    dmem_lsu_check #(.DMEM_AW(DMEM_AW)) u_check (
        .op_i   (req_op),
        .we_i   (req_we),
        .addr_i (req_addr),
        .err_o  (err_d)
    );

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign dmemaddr   = addr_q;
    assign dmemdatain = datain_q;
    assign dmemop     = op_q;
    assign dmemwe     = we_q;
    assign dmemrdclk  = rdclk_q;
    assign dmemwrclk  = wrclk_q;

    // Sequencer FSM; every output is a flop updated here.
    // A rejected request still passes through SETUP (with we held low and
    // no strobes) so the error answer arrives one edge after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            addr_q      <= 32'd0;
            datain_q    <= 32'd0;
            op_q        <= 3'd0;
            we_q        <= 1'b0;
            rdclk_q     <= 1'b0;
            wrclk_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= SETUP;
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        op_q        <= req_op;
                        datain_q    <= req_wdata;
                        we_q        <= req_we & ~err_d;
                        err_q       <= err_d;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (err_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        state_q <= RD_HI;
                        rdclk_q <= 1'b1;
                    end
                end
                RD_HI: begin
                    state_q <= RD_LO;
                    rdclk_q <= 1'b0;
                end
                RD_LO: begin
                    if (we_q) begin
                        state_q <= WR_HI;
                        wrclk_q <= 1'b1;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= dmemdataout;
                    end
                end
                WR_HI: begin
                    state_q <= WR_LO;
                    wrclk_q <= 1'b0;
                end
                WR_LO: begin
                    state_q     <= RESP;
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    we_q        <= 1'b0;
                    rdclk_q     <= 1'b0;
                    wrclk_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store sequencer between the rv32is core's memory request and the dmem data-memory block. It accepts one request at a time over a valid/ready handshake and checks alignment, range and op legality. It generates glitch-free registered dmemrdclk/dmemwrclk strobes, including the read-then-write sequence dmem needs for byte-masked stores. It returns load data or an error over a valid/ready response channel.

Parameters:
DMEM_AW, 17, number of byte-address bits backed by dmem; any set bit in addr[31:DMEM_AW] is out of range.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept a request; high only in IDLE
req_we  in  1  1=store, 0=load
req_op  in  3  memop: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  32  load result, already extended by dmem; 0 for stores and errors
rsp_err  out  1  request rejected; no memory access performed
dmemaddr  out  32  to dmem addr
dmemdatain  out  32  to dmem datain
dmemdataout  in  32  from dmem dataout
dmemop  out  3  to dmem memop
dmemwe  out  1  to dmem we
dmemrdclk  out  1  registered read strobe
dmemwrclk  out  1  registered write strobe

Behaviour:
- Clock and reset: one clock, named clock; reset is synchronous and active-high, named reset.
- Output registers: every dmem* output and every rsp* output is driven directly from a flop.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; dmemaddr=0; dmemdatain=0; dmemop=0; dmemwe=0; dmemrdclk=0; dmemwrclk=0.
- Accept: a request is taken when req_valid & req_ready. The accepting edge latches addr, op, wdata and we into the dmem* registers.
- Error checks, evaluated on the request fields at accept:
  - lh/lhu/sh with addr[0]=1.
  - lw/sw with addr[1:0]!=0.
  - Out of range: addr[31:DMEM_AW]!=0.
  - Illegal op: 011/110/111 for loads; anything other than 000/001/010 for stores.
- Error path: next state RESP with rsp_err=1 and rsp_rdata=0. dmemwe stays 0; no strobe pulses.
- States and transitions:
  - IDLE → SETUP on a legal accept.
  - SETUP: addr/op/datain stable; dmemwe=req_we; both strobes low.
  - SETUP → RD_HI: dmemrdclk=1. This edge captures read data, or old word data for a store.
  - RD_HI → RD_LO: dmemrdclk=0.
  - Load: RD_LO → RESP. The edge leaving RD_LO captures dmemdataout into rsp_rdata.
  - Store: RD_LO → WR_HI (dmemwrclk=1; the write commits on this edge) → WR_LO (dmemwrclk=0) → RESP.
  - dmemwe clears on the edge entering RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready. On rsp_valid & rsp_ready → IDLE; rsp_valid clears and req_ready sets on that edge.
- Latency, in edges from the accepting edge to rsp_valid high: load 3, store 5, error 1.
- Throughput: no overlap. req_ready=0 from the accepting edge until RESP completes.
- Strobe rules:
  - Each strobe is high for exactly one cycle per access.
  - dmemrdclk and dmemwrclk are never high simultaneously.
  - dmemaddr, dmemop and dmemwe never change while a strobe is high.
- Reset mid-operation:
  - Next edge forces IDLE and all reset values; strobes drop immediately.
  - Reset before WR_HI: the store does not commit.
  - Reset during or after WR_HI: the store has committed; no response is issued.
- req_valid while busy: ignored, not latched. The requester must hold it.

Decomposition:
- Shared package dmem_pkg:
  - memop encoding constants (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU).
  - LSU state enum (IDLE, SETUP, RD_HI, RD_LO, WR_HI, WR_LO, RESP).
  - DMEM_AW default.
- One natural sub-module: dmem_lsu_check. Purely combinational; computes err from op, we, addr and DMEM_AW. It is reused by the core for an exception-cause check.

Test Plan:
- Preload word 0x100=0xDEADBEEF; lw 0x100 → rsp_valid 3 edges after accept; rdata=0xDEADBEEF; err=0; one dmemrdclk pulse; no dmemwrclk pulse.
- Word 0x100=0x11223344; sb 0x000000A5 to 0x102 → rsp_valid 5 edges after accept; one pulse of each strobe, rd before wr; then lw 0x100 → 0x11A53344.
- Word 0x100=0x80000000; lb 0x103 → 0xFFFFFF80; lbu 0x103 → 0x00000080; lh 0x101 → err=1 after 1 edge, rdata=0, no strobes.
- DMEM_AW=17: lw 0x00020000 → err=1. Load op 3'b011 → err. Store op 3'b100 → err. Memory unchanged in all cases.
- lw, then rsp_ready held 0 for 4 cycles while a second req_valid is held → rsp_valid and rdata stable; req_ready=0; second request accepted only on the edge after rsp_ready.
- sw 0xCAFEF00D to 0x200 (old word 0x0); reset during RD_LO → IDLE next edge; no dmemwrclk pulse; lw 0x200 → 0x00000000.
